// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the core memory stage and a simple req/ack data memory.
// Read hits complete in the same cycle; misses refill a full line in word order.
// Optional build macro DCACHE_STATS_EN adds hit_cnt / miss_cnt counters.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [3:0]  write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_ready,
  output logic [31:0] ld_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 32 - 2 - WB - IB;

  typedef enum logic [1:0] {IDLE, REFILL, RDONE, WRITE} st_t;

  // Request captured when leaving IDLE; everything after IDLE works from this.
  typedef struct packed {
    logic [TB-1:0] tag;
    logic [IB-1:0] idx;
    logic [WB-1:0] word;
    logic [31:0]   wdata;
    logic [3:0]    strb;
  } req_t;

  st_t              st;
  req_t             req_q;
  logic [WB-1:0]    cnt;
  logic [31:0]      data_q [LINES][WORDS];
  logic [TB-1:0]    tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  // Byte offset is not used: the core only issues word accesses.
  logic unused_ofs;
  assign unused_ofs = ^addr[1:0];

  logic [WB-1:0] a_word;
  logic [IB-1:0] a_idx;
  logic [TB-1:0] a_tag;
  assign a_word = addr[2 +: WB];
  assign a_idx  = addr[2+WB +: IB];
  assign a_tag  = addr[31 -: TB];

  logic rd_req, hit, wr_hit, last;
  assign rd_req = read && (write == 4'b0);
  assign hit    = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign wr_hit = valid_q[req_q.idx] && (tag_q[req_q.idx] == req_q.tag);
  assign last   = (cnt == WB'(WORDS - 1));

  // Completion and load data: zero-wait on IDLE hit, from the refilled line in RDONE.
  always_comb begin
    data_ready = 1'b0;
    ld_data    = 32'h0;
    case (st)
      IDLE: if (rd_req && hit) begin
        data_ready = 1'b1;
        ld_data    = data_q[a_idx][a_word];
      end
      RDONE: begin
        data_ready = 1'b1;
        ld_data    = data_q[req_q.idx][req_q.word];
      end
      WRITE:   data_ready = mem_ack;
      default: ;
    endcase
  end

  // Control FSM with registered memory-port outputs and line valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      valid_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
`ifdef DCACHE_STATS_EN
      hit_cnt   <= 32'h0;
      miss_cnt  <= 32'h0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (write != 4'b0) begin
            // Store wins over a simultaneous load.
            st        <= WRITE;
            req_q     <= '{tag: a_tag, idx: a_idx, word: a_word, wdata: wdata, strb: write};
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
            mem_wstrb <= write;
          end else if (read && !hit) begin
            st        <= REFILL;
            cnt       <= '0;
            req_q     <= '{tag: a_tag, idx: a_idx, word: a_word, wdata: 32'h0, strb: 4'h0};
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {a_tag, a_idx, {WB{1'b0}}, 2'b00};
            mem_wstrb <= 4'h0;
`ifdef DCACHE_STATS_EN
            miss_cnt  <= miss_cnt + 32'd1;
`endif
          end else if (read) begin
`ifdef DCACHE_STATS_EN
            hit_cnt   <= hit_cnt + 32'd1;
`endif
          end
        end
        REFILL: if (mem_ack) begin
          if (last) begin
            valid_q[req_q.idx] <= 1'b1;
            mem_req            <= 1'b0;
            st                 <= RDONE;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= {req_q.tag, req_q.idx, cnt + 1'b1, 2'b00};
          end
        end
        RDONE: st <= IDLE;
        WRITE: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          st      <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  // Data and tag arrays: refill fill, write-through merge on hit; not reset.
  always_ff @(posedge clk) begin
    if (st == REFILL && mem_ack) begin
      data_q[req_q.idx][cnt] <= mem_rdata;
      if (last) tag_q[req_q.idx] <= req_q.tag;
    end
    if (st == WRITE && mem_ack && wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (req_q.strb[b]) data_q[req_q.idx][req_q.word][8*b +: 8] <= req_q.wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a 2-cycle-latency memory responder.
// Memory contents default to (addr>>2)+0x60, so line 0x100 reads 0xA0..0xA3.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [3:0]  write;
  logic [31:0] addr, wdata;
  logic        data_ready;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .data_ready(data_ready), .ld_data(ld_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Memory model with write-through storage.
  logic [31:0] mem [logic [31:0]];
  int          rd_acks = 0;
  int          wr_acks = 0;
  logic [31:0] rd_log [$];
  logic [31:0] w_addr, w_data;
  logic [3:0]  w_strb;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a >> 2) + 32'h60;
  endfunction

  // Responder: raise ack 2 cycles into each request, drop it after one cycle.
  initial begin
    int wt;
    logic [31:0] cur;
    wt = 0; mem_ack = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst || mem_ack) begin
        mem_ack = 1'b0; wt = 0;
      end else if (mem_req) begin
        wt++;
        if (wt == 2) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            cur = mem_rd(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = cur;
            w_addr = mem_addr; w_data = mem_wdata; w_strb = mem_wstrb;
            wr_acks++;
          end else begin
            mem_rdata = mem_rd(mem_addr);
            rd_log.push_back(mem_addr);
            rd_acks++;
          end
        end
      end
    end
  end

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit got;
    int c;
    got = 0; lat = 0; d = 32'h0; c = 0;
    @(negedge clk); #2;
    addr = a; read = 1'b1; write = 4'h0;
    #1;
    while (!got && c < 64) begin
      if (data_ready) begin
        got = 1; d = ld_data;
      end else begin
        @(negedge clk); #3;
        lat++;
      end
      c++;
    end
    chk("rd_done", 32'(got), 32'd1);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input bit also_rd);
    bit got;
    int c;
    got = 0; c = 0;
    @(negedge clk); #2;
    addr = a; wdata = d; write = s; read = also_rd;
    #1;
    while (!got && c < 64) begin
      if (data_ready) got = 1;
      else begin
        @(negedge clk); #3;
      end
      c++;
    end
    chk("wr_done", 32'(got), 32'd1);
    @(posedge clk); #1;
    write = 4'h0; read = 1'b0;
  endtask

  task automatic rd_miss(input logic [31:0] a, input logic [31:0] exp_d, input string tag);
    logic [31:0] d;
    int lat, base;
    base = rd_acks;
    rd_log.delete();
    rd(a, d, lat);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_nacks"}, 32'(rd_acks - base), 32'd4);
    for (int i = 0; i < 4; i++)
      if (rd_log.size() > 0) chk({tag, "_addr"}, rd_log.pop_front(), {a[31:4], 4'h0} + 32'(4*i));
    @(negedge clk); #3;
    chk({tag, "_req_off"}, 32'(mem_req), 32'd0);
  endtask

  task automatic rd_hit(input logic [31:0] a, input logic [31:0] exp_d, input string tag);
    logic [31:0] d;
    int lat, base;
    base = rd_acks;
    rd(a, d, lat);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_lat"}, 32'(lat), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_nacks"}, 32'(rd_acks - base), 32'd0);
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                    input bit also_rd, input string tag);
    int wb, rb;
    wb = wr_acks; rb = rd_acks;
    wr(a, s, d, also_rd);
    chk({tag, "_nw"}, 32'(wr_acks - wb), 32'd1);
    chk({tag, "_nr"}, 32'(rd_acks - rb), 32'd0);
    chk({tag, "_addr"}, w_addr, a);
    chk({tag, "_wdata"}, w_data, d);
    chk({tag, "_strb"}, 32'(w_strb), 32'(s));
  endtask

  initial begin
    int base, c;
    rst = 1'b0; read = 1'b0; write = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_dr", 32'(data_ready), 32'd0);
    chk("rst_ld", ld_data, 32'h0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_strb", 32'(mem_wstrb), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Cold miss and refill, then same-cycle hit.
    rd_miss(32'h100, 32'h0000_00A0, "miss100");
    rd_hit(32'h108, 32'h0000_00A2, "hit108");

    // Write-through hits with byte merge; second store has read asserted too.
    st(32'h104, 4'b0011, 32'h0000_BEEF, 1'b0, "st104");
    rd_hit(32'h104, 32'h0000_BEEF, "hit104");
    st(32'h108, 4'b1100, 32'hCAFE_0000, 1'b1, "st108");
    rd_hit(32'h108, 32'hCAFE_00A2, "hit108m");

    // Store miss does not allocate; line 0 still holds tag 1.
    st(32'h400, 4'b1111, 32'h1122_3344, 1'b0, "st400");
    rd_hit(32'h100, 32'h0000_00A0, "hit100");
    rd_miss(32'h400, 32'h1122_3344, "miss400");

    // Conflict misses on index 0; written-through data comes back from memory.
    rd_miss(32'h500, 32'h0000_01A0, "miss500");
    rd_miss(32'h100, 32'h0000_00A0, "miss100b");
    rd_hit(32'h104, 32'h0000_BEEF, "hit104b");
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_mid", hit_cnt, 32'd5);
    chk("miss_cnt_mid", miss_cnt, 32'd4);
`endif

    // Reset in the middle of a refill after two acks.
    base = rd_acks; c = 0;
    @(negedge clk); #2;
    addr = 32'h200; read = 1'b1;
    while (rd_acks < base + 2 && c < 64) begin
      @(posedge clk); c++;
    end
    chk("pre_rst_acks", 32'(rd_acks - base), 32'd2);
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b0; read = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_maddr", mem_addr, 32'h0);
    chk("mid_rst_dr", 32'(data_ready), 32'd0);
    chk("mid_rst_ld", ld_data, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Valid bits were cleared: line 0x100 must refill completely.
    rd_miss(32'h100, 32'h0000_00A0, "miss100c");
    rd_hit(32'h108, 32'hCAFE_00A2, "hit108c");
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_end", hit_cnt, 32'd1);
    chk("miss_cnt_end", miss_cnt, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog in case a wait escapes its bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

endmodule
